// File: rtl/im_fetch.sv
// Synchronous-read instruction memory for the fetch stage: run-time program port,
// valid/ready fetch with a one-entry response register, and a post-reset clear sweep.
module im_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_ins,
    output logic              rsp_err,
    output logic              busy
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_ins;
    logic              r_rsp_err;

    logic              w_run;
    logic              w_prog_hit;
    logic              w_req_hit;
    logic              w_accept;
    logic              w_wr_en;
    logic [MEM_AW-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_bypass;

    // Range checks use the full address width so nothing aliases past DEPTH.
    assign w_run      = (r_state == ST_RUN);
    assign w_prog_hit = ({1'b0, prog_addr} < DEPTH_EXT);
    assign w_req_hit  = ({1'b0, req_addr} < DEPTH_EXT);

    assign req_ready = !rst && w_run && (!r_rsp_valid || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // The sweep owns the write port until RUN; program writes only land afterwards.
    assign w_wr_en   = !rst && (!w_run || (prog_we && w_prog_hit));
    assign w_wr_addr = w_run ? prog_addr[MEM_AW-1:0] : r_idx[MEM_AW-1:0];
    assign w_wr_data = w_run ? prog_data : '0;
    assign w_bypass  = prog_we && w_prog_hit && (prog_addr == req_addr);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else if (!w_run) begin
            if (r_idx == LAST_IDX) begin
                r_state <= ST_RUN;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Write-first on a same-address collision: forward prog_data around the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_ins   <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            if (w_req_hit) begin
                r_rsp_ins <= w_bypass ? prog_data : mem[req_addr[MEM_AW-1:0]];
                r_rsp_err <= 1'b0;
            end else begin
                r_rsp_ins <= '0;
                r_rsp_err <= 1'b1;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_ins   = r_rsp_ins;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_im_fetch.sv
// Directed bench for im_fetch: sweep timing, programming, back-to-back fetch,
// backpressure, range errors, write/fetch collision and reset mid-stream.
module tb_im_fetch;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_ins;
    logic              rsp_err;
    logic              busy;

    int n_vec  = 0;
    int n_miss = 0;

    im_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ins   (rsp_ins),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] ins, input logic err);
        chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".ins"}, rsp_ins, ins);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, err});
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd0);
            tick();
            chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        end
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst.busy", {31'd0, busy}, 32'd1);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_ins", rsp_ins, 32'd0);
        chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd0);

        // Sweep with a pending fetch and a program write that must both be ignored.
        rst = 1'b0; req_valid = 1'b1; req_addr = 16'd5; rsp_ready = 1'b1;
        prog_we = 1'b1; prog_addr = 16'd7; prog_data = 32'hDEADBEEF;
        sweep("sweep1");
        prog_we = 1'b0;
        #1;
        chk("run.req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk_rsp("fetch5", 32'h0, 1'b0);
        req_addr = 16'd7;
        tick();
        chk_rsp("fetch7", 32'h0, 1'b0);

        req_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 16'd0; prog_data = 32'h04100000;
        tick();
        chk("idle.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        prog_addr = 16'd1; prog_data = 32'h00120001;
        tick();
        prog_we = 1'b0;
        req_valid = 1'b1; req_addr = 16'd0;
        tick();
        chk_rsp("b2b0", 32'h04100000, 1'b0);
        req_addr = 16'd1;
        tick();
        chk_rsp("b2b1", 32'h00120001, 1'b0);

        // Backpressure: a different address is offered so a wrongly accepted fetch shows.
        rsp_ready = 1'b0; req_addr = 16'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.req_ready", {31'd0, req_ready}, 32'd0);
            tick();
            chk_rsp("bp.hold", 32'h00120001, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk_rsp("bp.next", 32'h04100000, 1'b0);

        req_addr = 16'h0100;
        tick();
        chk_rsp("oor256", 32'h0, 1'b1);
        req_addr = 16'hFFFF;
        tick();
        chk_rsp("oorFFFF", 32'h0, 1'b1);

        req_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 16'd44; prog_data = 32'h0000002C;
        tick();
        prog_addr = 16'd300; prog_data = 32'hFFFFFFFF;
        tick();
        prog_addr = 16'd255; prog_data = 32'hA5A5_00FF;
        tick();
        prog_we = 1'b0;
        req_valid = 1'b1; req_addr = 16'd44;
        tick();
        chk_rsp("alias44", 32'h0000002C, 1'b0);
        req_addr = 16'd300;
        tick();
        chk_rsp("oor300", 32'h0, 1'b1);
        req_addr = 16'd255;
        tick();
        chk_rsp("top255", 32'hA5A5_00FF, 1'b0);

        prog_we = 1'b1; prog_addr = 16'd9; prog_data = 32'h8000002B; req_addr = 16'd9;
        tick();
        chk_rsp("collide9", 32'h8000002B, 1'b0);
        prog_we = 1'b0;
        tick();
        chk_rsp("refetch9", 32'h8000002B, 1'b0);

        // Reset while a response is pending, then a full fresh sweep.
        rsp_ready = 1'b0; rst = 1'b1;
        tick();
        chk("mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid.rsp_ins", rsp_ins, 32'd0);
        chk("mid.busy", {31'd0, busy}, 32'd1);
        rst = 1'b0; rsp_ready = 1'b1; req_addr = 16'd0;
        sweep("sweep2");
        tick();
        chk_rsp("post0", 32'h0, 1'b0);
        req_addr = 16'd9;
        tick();
        chk_rsp("post9", 32'h0, 1'b0);
        req_valid = 1'b0;
        tick();
        chk("drain.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/im_fetch.md
# im_fetch

Parametrised, synchronous-read instruction memory for the CPU fetch stage. It replaces the fixed 256×32 combinational instruction store. Instructions are loaded at run time through a program-write port. Fetches use a valid/ready request/response handshake with one-cycle latency and an out-of-range error flag. After reset, a hardware sweep clears every word to zero before the first fetch is accepted.

## Interface
- DATA_W, 32: instruction width in bits
- ADDR_W, 16: word-address width of both ports
- DEPTH, 256: number of instruction words; 2 ≤ DEPTH ≤ 2^ADDR_W

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- prog_we  in  1  program-write strobe
- prog_addr  in  ADDR_W  program-write word address
- prog_data  in  DATA_W  program-write data
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request can be accepted
- req_addr  in  ADDR_W  fetch word address (PC)
- rsp_valid  out  1  fetch response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_ins  out  DATA_W  fetched instruction
- rsp_err  out  1  the fetched address was ≥ DEPTH
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR and RUN.
- While rst=1: state is CLEAR, the clear index is 0, busy=1, rsp_valid=0, rsp_ins=0, rsp_err=0, req_ready=0.
- CLEAR:
  - Each cycle with rst=0, write 0 to mem[idx] and increment idx.
  - After the write to idx=DEPTH-1, go to RUN.
  - prog_we is ignored. req_ready=0.
- RUN:
  - busy=0.
  - req_ready = !rsp_valid || rsp_ready. This is a single-entry output register with full throughput.
- Fetch acceptance: a fetch is accepted on a cycle where req_valid && req_ready.
  - Next cycle: rsp_valid=1.
  - If req_addr < DEPTH: rsp_ins = mem[req_addr], rsp_err = 0.
  - Otherwise: rsp_ins = 0, rsp_err = 1.
- Response hold: while rsp_valid && !rsp_ready, rsp_ins and rsp_err hold stable, and no new request is accepted.
- Response clear: rsp_valid drops when rsp_ready=1 and no request is accepted in the same cycle.
- Program write: in RUN, prog_we=1 with prog_addr < DEPTH writes prog_data to mem[prog_addr]. Writes with prog_addr ≥ DEPTH are dropped silently.
- Write/fetch collision: a write and an accepted fetch to the same address in the same cycle use write-first ordering. The response carries the new prog_data.
- Address compare: use the full ADDR_W bits. There is no wrap-around or aliasing for non-power-of-two DEPTH.
- Memory contents are not reset directly; only the sweep zeroes them.

## Timing
- Fetch latency is exactly 1 cycle, from the accepting edge to rsp_valid=1.
- Sustained throughput is 1 fetch per cycle when rsp_ready is held at 1.
- busy stays high for exactly DEPTH cycles after the first cycle with rst=0. The first fetch can be accepted on cycle DEPTH, counting from 0 at that first cycle.
- rst asserted mid-sweep or mid-fetch: on the next edge the outstanding response is discarded (rsp_valid=0) and the sweep restarts from idx=0. Program data written before the reset is lost.
- All outputs are registered except req_ready, which is combinational from state, rsp_valid and rsp_ready.

## Test plan
- Reset sweep, DEPTH=256: release rst → busy=1 for 256 cycles and req_ready=0 throughout. Then fetch addr 5 → rsp_ins=0, rsp_err=0.
- Program and back-to-back fetch: write 0x04100000 to addr 0 and 0x00120001 to addr 1. Fetch 0, then 1, on consecutive cycles with rsp_ready=1 → responses appear on consecutive cycles with those values.
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 (addr 1) → req_ready=0 and rsp_ins stays stable. Raise rsp_ready → the next request is accepted in the same cycle.
- Out of range, DEPTH=256: fetch addr 0x0100 → rsp_err=1, rsp_ins=0. Write to addr 300 → memory unchanged (a fetch of addr 300 mod 256 = 44 still returns its old value).
- Collision: in the same cycle, write 0x8000002B to addr 9 and fetch addr 9 → rsp_ins=0x8000002B.
- Reset mid-stream: assert rst while rsp_valid=1 → rsp_valid=0 next cycle, then a full 256-cycle sweep, then fetch addr 0 → 0.
